pbuf_chain_programmer: RTL and testbench
========================================

// Module: pbuf_chain_programmer
// PURPOSE
//  Drives the two-phase configuration chain of pbuf6-style tristate buffer banks.
//  Takes a parallel config word over a valid/ready handshake.
//  Serialises it onto prog_in with non-overlapping prog_clk0/prog_clk1 pulses derived from one system clock.
//  Captures the old chain contents returning on prog_out, so the previous configuration is read back.
//  Sits between the SoC config registers and the head of the pbuf chain.
// PARAMETERS
//  CHAIN_LEN     6  number of chain stages (bits) shifted per transaction; >=1
//  PHASE_CYCLES  2  clk cycles per SETUP, CLK0-high and CLK1-high interval; >=1
//  GAP_CYCLES    1  clk cycles with both prog clocks low after each pulse; >=1
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  rst            in   1          asynchronous, active-high reset
//  cfg_valid      in   1          config word offered
//  cfg_ready      out  1          programmer idle, can accept
//  cfg_data       in   CHAIN_LEN  word to load; bit i lands in chain stage i
//  busy           out  1          transaction in progress
//  done           out  1          one-cycle pulse, transaction complete
//  readback_data  out  CHAIN_LEN  chain contents before last transaction, bit i = old stage i
//  prog_in        out  1          serial data to chain head
//  prog_clk0      out  1          phase-0 chain clock
//  prog_clk1      out  1          phase-1 chain clock
//  prog_out       in   1          serial data from chain tail
// BEHAVIOUR
//  Reset values (async, immediate):
//   - prog_clk0 = prog_clk1 = prog_in = 0; busy = 0; done = 0; cfg_ready = 1; readback_data = 0.
//  All outputs are registered; no combinational path from any input to any output.
//  Accept:
//   - In IDLE, cfg_valid & cfg_ready captures cfg_data into the shift register.
//   - busy = 1 and cfg_ready = 0 from the next cycle.
//   - cfg_valid while busy is ignored; no data is lost because ready is low.
//  Per-bit FSM: IDLE -> SETUP(P) -> CLK0(P) -> GAP0(G) -> CLK1(P) -> GAP1(G)
//   - GAP1 goes to SETUP for the next bit, or to IDLE after bit 0.
//   - P = PHASE_CYCLES, G = GAP_CYCLES.
//  SETUP, first cycle:
//   - prog_in <= shift_reg[CHAIN_LEN-1], i.e. MSB first.
//   - prog_in is stable through the whole bit and changes only while both clocks are low.
//  SETUP, last cycle:
//   - Sample prog_out into readback shift (LSB in, shifting left).
//   - After CHAIN_LEN bits, readback_data holds the old contents.
//  CLK0: prog_clk0 = 1. CLK1: prog_clk1 = 1. All other states: both clocks 0.
//  Invariants:
//   - prog_clk0 & prog_clk1 is never 1.
//   - At least G cycles with both clocks low between any two pulses.
//  Latency:
//   - Accept to done = CHAIN_LEN*(3P+2G) cycles; 48 with the defaults.
//   - done pulses in the first IDLE cycle, with busy = 0 and cfg_ready = 1.
//   - An accept in the done cycle is legal (back-to-back).
//   - readback_data updates only at done and holds until the next done.
//  Bit counter counts CHAIN_LEN-1 down to 0. Phase counter width is clog2(max(P,G)+1).
//   - Both wrap only through reload; no free-running wrap.
//  Reset mid-transaction:
//   - Clocks drop low immediately and the FSM returns to IDLE.
//   - Chain contents are undefined; software must reprogram.
//   - No done pulse is issued.
//  CHAIN_LEN = 1: single bit per transaction, same timing rules.
// STRUCTURE
//  Shared include pbuf_defs.vh:
//   - FSM state localparams IDLE/SETUP/CLK0/GAP0/CLK1/GAP1, 3-bit encoding.
//   - Default CHAIN_LEN/PHASE_CYCLES/GAP_CYCLES.
//  Sub-module pbuf_phase_gen:
//   - Owns the per-bit phase FSM, the phase counter and the registered prog_clk0/prog_clk1.
//   - Takes a start pulse; emits sample_strobe and bit_done.
//  Top level:
//   - Handshake, data/readback shift registers and bit counter.
// TESTING (bench instantiates a real pbuf6 as load, prog_out looped back)
//  1. Reset, load cfg_data=6'b010101
//     -> done after 48 cycles; pbuf6 enables bits 0,2,4 pass in; readback_data=6'b000000.
//  2. Back-to-back: load 6'b111111, then 6'b000000 on the done cycle
//     -> second readback_data=6'b111111; all pbuf6 outputs tri-state.
//  3. Hold cfg_valid high with changing data while busy
//     -> only the first word is loaded; cfg_ready stays 0 until done.
//  4. Protocol assertions over the whole run:
//     -> clocks never overlap; >=1 both-low cycle between pulses; prog_in changes only with both clocks low.
//  5. Assert rst at cycle 20 of a transaction
//     -> prog_clk0/1, prog_in, busy drop to 0 asynchronously; no done; reload 6'b100001 reads back as programmed.
//  6. Parameter sweep CHAIN_LEN=1, PHASE_CYCLES=3, GAP_CYCLES=2
//     -> done after 13 cycles; readback correct.

Source files
------------

// File: rtl/pbuf_chain_programmer_pkg.sv
// Package for the pbuf configuration-chain programmer.
// Holds the default geometry, the per-bit phase state encoding and the
// helpers that size the phase and bit counters.
package pbuf_chain_programmer_pkg;

  localparam int DEF_CHAIN_LEN    = 6;
  localparam int DEF_PHASE_CYCLES = 2;
  localparam int DEF_GAP_CYCLES   = 1;

  // One chain bit walks SETUP -> CLK0 -> GAP0 -> CLK1 -> GAP1.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CLK0  = 3'd2,
    ST_GAP0  = 3'd3,
    ST_CLK1  = 3'd4,
    ST_GAP1  = 3'd5
  } phase_state_t;

  // Phase counter must hold max(P, G); it is always reloaded, never wraps.
  function automatic int phase_cnt_width(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    return $clog2(m + 1);
  endfunction

  // Bit counter runs CHAIN_LEN-1 down to 0; keep it at least one bit wide.
  function automatic int bit_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbuf_chain_programmer_if.sv
// Bus between the SoC config side, the programmer and the pbuf chain.
//   cfg_valid/cfg_ready/cfg_data : config word handshake
//   busy/done/readback_data      : status and previous chain contents
//   prog_in/prog_clk0/prog_clk1  : serial data and two-phase chain clocks
//   prog_out                     : serial data returning from the chain tail
// The slave modport is the programmer; the master modport is its environment.
interface pbuf_chain_programmer_if #(
  parameter int CHAIN_LEN = pbuf_chain_programmer_pkg::DEF_CHAIN_LEN
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAIN_LEN-1:0] cfg_data;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] readback_data;
  logic                 prog_in;
  logic                 prog_clk0;
  logic                 prog_clk1;
  logic                 prog_out;

  modport slave (
    input  cfg_valid, cfg_data, prog_out,
    output cfg_ready, busy, done, readback_data, prog_in, prog_clk0, prog_clk1
  );

  modport master (
    output cfg_valid, cfg_data, prog_out,
    input  cfg_ready, busy, done, readback_data, prog_in, prog_clk0, prog_clk1
  );
endinterface

// File: rtl/pbuf_chain_programmer_phase_gen.sv
// Per-bit phase generator for the pbuf configuration chain.
// Sequences SETUP(P) -> CLK0(P) -> GAP0(G) -> CLK1(P) -> GAP1(G) for each bit
// and drives registered, non-overlapping prog_clk0/prog_clk1.
//   clk, rst          : system clock, asynchronous active-high reset
//   i_start           : accept pulse, starts the first bit (only seen in IDLE)
//   i_last_bit        : current bit is the final one; GAP1 returns to IDLE
//   o_sample_strobe   : last SETUP cycle, sample prog_out
//   o_bit_done        : last GAP1 cycle, advance to the next bit
//   o_prog_clk0/1     : phase-0 / phase-1 chain clocks
module pbuf_chain_programmer_phase_gen
  import pbuf_chain_programmer_pkg::*;
#(
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_last_bit,
  output logic o_sample_strobe,
  output logic o_bit_done,
  output logic o_prog_clk0,
  output logic o_prog_clk1
);

  localparam int CW = phase_cnt_width(PHASE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] P_RELOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] G_RELOAD = CW'(GAP_CYCLES - 1);

  phase_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_prog_clk0, r_prog_clk1;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_IDLE) begin
      if (i_start) begin
        w_state_nxt = ST_SETUP;
        w_cnt_nxt   = P_RELOAD;
      end
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end else begin
      case (r_state)
        ST_SETUP: begin w_state_nxt = ST_CLK0; w_cnt_nxt = P_RELOAD; end
        ST_CLK0:  begin w_state_nxt = ST_GAP0; w_cnt_nxt = G_RELOAD; end
        ST_GAP0:  begin w_state_nxt = ST_CLK1; w_cnt_nxt = P_RELOAD; end
        ST_CLK1:  begin w_state_nxt = ST_GAP1; w_cnt_nxt = G_RELOAD; end
        ST_GAP1: begin
          if (i_last_bit) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = P_RELOAD;
          end
        end
        default: begin w_state_nxt = ST_IDLE; w_cnt_nxt = '0; end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_prog_clk0 <= 1'b0;
      r_prog_clk1 <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Clocks are decoded from the next state into flops: glitch-free,
      // and they drop together with the async reset.
      r_prog_clk0 <= (w_state_nxt == ST_CLK0);
      r_prog_clk1 <= (w_state_nxt == ST_CLK1);
    end
  end

  assign o_sample_strobe = (r_state == ST_SETUP) && w_cnt_zero;
  assign o_bit_done      = (r_state == ST_GAP1) && w_cnt_zero;
  assign o_prog_clk0     = r_prog_clk0;
  assign o_prog_clk1     = r_prog_clk1;

endmodule

// File: rtl/pbuf_chain_programmer.sv
// Programmer for the two-phase configuration chain of pbuf6-style buffer banks.
// Accepts a parallel word over valid/ready, shifts it MSB first onto prog_in
// using non-overlapping prog_clk0/prog_clk1, and collects the old chain
// contents from prog_out into readback_data.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of pbuf_chain_programmer_if (handshake, status,
//              readback, serial chain signals)
// All outputs come straight from flops.
module pbuf_chain_programmer
  import pbuf_chain_programmer_pkg::*;
#(
  parameter int CHAIN_LEN    = DEF_CHAIN_LEN,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  pbuf_chain_programmer_if.slave bus
);

  localparam int BW = bit_cnt_width(CHAIN_LEN);

  logic                 r_ready, r_busy, r_done, r_prog_in;
  logic [CHAIN_LEN-1:0] r_shift;      // bits still to send, next one at MSB
  logic [CHAIN_LEN-1:0] r_rb_shift;   // old chain bits collected so far
  logic [CHAIN_LEN-1:0] r_readback;
  logic [BW-1:0]        r_bit_cnt;

  logic w_accept, w_last_bit, w_sample, w_bit_done, w_finish;
  logic w_prog_clk0, w_prog_clk1;

  assign w_accept   = bus.cfg_valid & r_ready;
  assign w_last_bit = (r_bit_cnt == '0);
  assign w_finish   = w_bit_done & w_last_bit;

  pbuf_chain_programmer_phase_gen #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_phase_gen (
    .clk             (clk),
    .rst             (rst),
    .i_start         (w_accept),
    .i_last_bit      (w_last_bit),
    .o_sample_strobe (w_sample),
    .o_bit_done      (w_bit_done),
    .o_prog_clk0     (w_prog_clk0),
    .o_prog_clk1     (w_prog_clk1)
  );

  // Handshake: ready and busy flip together on accept and on the final bit,
  // so a new word can be taken in the very cycle done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_finish) begin
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  // Data path. prog_in is loaded on entry to SETUP (accept or end of the
  // previous bit), when both chain clocks are low, and then held for the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_prog_in  <= 1'b0;
      r_bit_cnt  <= '0;
      r_rb_shift <= '0;
      r_readback <= '0;
    end else begin
      if (w_accept) begin
        r_prog_in <= bus.cfg_data[CHAIN_LEN-1];
        r_shift   <= bus.cfg_data << 1;
        r_bit_cnt <= BW'(CHAIN_LEN - 1);
      end else if (w_bit_done && !w_last_bit) begin
        r_prog_in <= r_shift[CHAIN_LEN-1];
        r_shift   <= r_shift << 1;
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      // The chain tail is read before this bit's clocks shift it, so the
      // first sample is old stage CHAIN_LEN-1 and ends up at the MSB.
      if (w_sample) begin
        r_rb_shift <= (r_rb_shift << 1) | CHAIN_LEN'(bus.prog_out);
      end
      if (w_finish) begin
        r_readback <= r_rb_shift;
      end
    end
  end

  assign bus.cfg_ready     = r_ready;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.readback_data = r_readback;
  assign bus.prog_in       = r_prog_in;
  assign bus.prog_clk0     = w_prog_clk0;
  assign bus.prog_clk1     = w_prog_clk1;

endmodule

// File: tb/tb_pbuf_chain_programmer.sv
// Bench for pbuf_chain_programmer: a default instance (6 bits, P=2, G=1) and
// a swept instance (1 bit, P=3, G=2), each loaded by a behavioural
// two-phase pbuf chain whose tail is looped back to prog_out.
module tb_pbuf_chain_programmer;

  localparam int N_A = 6, P_A = 2, G_A = 1;
  localparam int N_S = 1, P_S = 3, G_S = 2;
  localparam int LAT_A = N_A * (3 * P_A + 2 * G_A);  // 48
  localparam int LAT_S = N_S * (3 * P_S + 2 * G_S);  // 13

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pbuf_chain_programmer_if #(.CHAIN_LEN(N_A)) if_a ();
  pbuf_chain_programmer_if #(.CHAIN_LEN(N_S)) if_s ();

  pbuf_chain_programmer #(.CHAIN_LEN(N_A), .PHASE_CYCLES(P_A), .GAP_CYCLES(G_A))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pbuf_chain_programmer #(.CHAIN_LEN(N_S), .PHASE_CYCLES(P_S), .GAP_CYCLES(G_S))
    u_dut_s (.clk(clk), .rst(rst), .bus(if_s));

  // Behavioural pbuf chain: clk0 captures head data plus the shifted stages
  // into the master latches, clk1 transfers them to the stage outputs.
  logic [N_A-1:0] chain_a = '0, master_a = '0;
  logic [N_S-1:0] chain_s = '0, master_s = '0;
  always @(posedge if_a.prog_clk0) master_a = {chain_a[N_A-2:0], if_a.prog_in};
  always @(posedge if_a.prog_clk1) chain_a = master_a;
  always @(posedge if_s.prog_clk0) master_s = if_s.prog_in;
  always @(posedge if_s.prog_clk1) chain_s = master_s;
  assign if_a.prog_out = chain_a[N_A-1];
  assign if_s.prog_out = chain_s[N_S-1];

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Selected instance view (0 = default, 1 = swept).
  bit sel = 1'b0;
  logic m_ready, m_busy, m_done;
  logic [5:0] m_rb, m_chain;
  always_comb begin
    if (sel) begin
      m_ready = if_s.cfg_ready; m_busy = if_s.busy; m_done = if_s.done;
      m_rb = {5'b0, if_s.readback_data}; m_chain = {5'b0, chain_s};
    end else begin
      m_ready = if_a.cfg_ready; m_busy = if_a.busy; m_done = if_a.done;
      m_rb = if_a.readback_data; m_chain = chain_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic v, input logic [5:0] d);
    if (sel) begin if_s.cfg_valid = v; if_s.cfg_data = d[0]; end
    else     begin if_a.cfg_valid = v; if_a.cfg_data = d;    end
  endtask

  // Reference model: the chain holds the last completed word; a transaction
  // reads back the previous word, and readback holds between dones.
  logic [5:0] last_cfg [2] = '{6'd0, 6'd0};
  logic [5:0] last_rb  [2] = '{6'd0, 6'd0};
  bit         rb_known [2] = '{1'b1, 1'b1};

  task automatic load(input logic [5:0] data_in, input bit chk_rb, output logic [5:0] rb_o);
    int n;
    int lat_exp;
    logic [5:0] data;
    data    = sel ? {5'b0, data_in[0]} : data_in;
    lat_exp = sel ? LAT_S : LAT_A;
    n = 0;
    while (!m_ready && n < 200) begin tick(); n++; end
    check("ready_idle", m_ready, 1);
    drive_cfg(1'b1, data);
    tick();
    drive_cfg(1'b0, 6'($urandom));
    check("busy_after_accept", m_busy, 1);
    check("ready_after_accept", m_ready, 0);
    if (rb_known[sel]) check("readback_hold", m_rb, last_rb[sel]);
    n = 0;
    while (!m_done && n < 200) begin tick(); n++; end
    check("latency", n, lat_exp);
    check("done_busy", m_busy, 0);
    check("done_ready", m_ready, 1);
    check("chain_contents", m_chain, data);
    if (chk_rb) check("readback", m_rb, last_cfg[sel]);
    rb_o          = m_rb;
    last_rb[sel]  = last_cfg[sel];
    rb_known[sel] = chk_rb;
    last_cfg[sel] = data;
  endtask

  // Protocol monitor on the falling edge, for both instances.
  logic pc0 [2] = '{1'b0, 1'b0};
  logic pc1 [2] = '{1'b0, 1'b0};
  logic ppi [2] = '{1'b0, 1'b0};
  int   low_run [2] = '{0, 0};
  bit   seen [2] = '{1'b0, 1'b0};
  logic mc0, mc1, mpi;
  int   mgap;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pc0[d] = 1'b0; pc1[d] = 1'b0; ppi[d] = 1'b0; low_run[d] = 0; seen[d] = 1'b0;
      end else begin
        mc0  = d ? if_s.prog_clk0 : if_a.prog_clk0;
        mc1  = d ? if_s.prog_clk1 : if_a.prog_clk1;
        mpi  = d ? if_s.prog_in   : if_a.prog_in;
        mgap = d ? G_S : G_A;
        if (mc0 | mc1)
          check("clk_exclusive", {29'd0, mc0 & mc1, mc0 & pc1[d], mc1 & pc0[d]}, 0);
        if ((mc0 | mc1) && !(pc0[d] | pc1[d]) && seen[d])
          check("pulse_gap", low_run[d] >= mgap, 1);
        if (mpi !== ppi[d])
          check("prog_in_stable", mc0 | mc1 | pc0[d] | pc1[d], 0);
        if (mc0 | mc1) begin low_run[d] = 0; seen[d] = 1'b1; end
        else low_run[d] = low_run[d] + 1;
        pc0[d] = mc0; pc1[d] = mc1; ppi[d] = mpi;
      end
    end
  end

  typedef struct {
    logic [5:0] cfg;
    logic [5:0] exp_rb;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [5];
    logic [5:0] rb;
    int cnt, gap;
    bit done_seen;

    tbl[0] = '{6'b010101, 6'b000000};
    tbl[1] = '{6'b111111, 6'b010101};
    tbl[2] = '{6'b000000, 6'b111111};
    tbl[3] = '{6'b101100, 6'b000000};
    tbl[4] = '{6'b011011, 6'b101100};

    if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
    if_s.cfg_valid = 1'b0; if_s.cfg_data = '0;
    rst = 1'b1;
    #2;
    check("rst_clk0", if_a.prog_clk0, 0);
    check("rst_clk1", if_a.prog_clk1, 0);
    check("rst_prog_in", if_a.prog_in, 0);
    check("rst_busy", if_a.busy, 0);
    check("rst_done", if_a.done, 0);
    check("rst_ready", if_a.cfg_ready, 1);
    check("rst_readback", if_a.readback_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Table: back-to-back loads, each accepted in the previous done cycle.
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load(tbl[i].cfg, 1'b1, rb);
      check("table_readback", rb, tbl[i].exp_rb);
    end
    tick();
    check("done_one_cycle", m_done, 0);

    // cfg_valid held high with changing data while busy: first word only.
    drive_cfg(1'b1, 6'b110010);
    tick();
    check("hold_busy", m_busy, 1);
    cnt = 0;
    gap = 0;
    while (!m_done && gap < 200) begin
      drive_cfg(1'b1, 6'($urandom));
      tick();
      gap++;
      if (!m_done && m_ready) cnt++;
    end
    drive_cfg(1'b0, 6'd0);
    check("hold_ready_low", cnt, 0);
    check("hold_latency", gap, LAT_A);
    check("hold_chain", m_chain, 6'b110010);
    check("hold_readback", m_rb, last_cfg[0]);
    last_rb[0] = last_cfg[0];
    last_cfg[0] = 6'b110010;

    // Random words with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        tick();
        check("done_one_cycle_rand", m_done, 0);
        repeat (gap - 1) tick();
      end
      load(6'($urandom), 1'b1, rb);
    end

    // Reset in cycle 20 of a transaction: CLK0 of the third bit (cfg[3]).
    drive_cfg(1'b1, 6'b101110);
    tick();
    drive_cfg(1'b0, 6'd0);
    repeat (19) tick();
    check("c20_clk0", if_a.prog_clk0, 1);
    check("c20_prog_in", if_a.prog_in, 1);
    check("c20_busy", if_a.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_clk0", if_a.prog_clk0, 0);
    check("arst_clk1", if_a.prog_clk1, 0);
    check("arst_prog_in", if_a.prog_in, 0);
    check("arst_busy", if_a.busy, 0);
    check("arst_ready", if_a.cfg_ready, 1);
    done_seen = if_a.done;
    repeat (3) begin tick(); done_seen |= if_a.done; end
    rst = 1'b0;
    repeat (5) begin tick(); done_seen |= if_a.done; end
    check("arst_no_done", done_seen, 0);
    check("arst_readback", if_a.readback_data, 0);
    last_rb[0] = '0; rb_known[0] = 1'b1;
    last_rb[1] = '0; rb_known[1] = 1'b1;
    load(6'b100001, 1'b0, rb);
    load(6'($urandom), 1'b1, rb);
    check("reload_readback", rb, 6'b100001);

    // Swept instance: 1 bit, P=3, G=2.
    sel = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      load(6'($urandom), 1'b1, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
